stage1_issue_ctrl: RTL and testbench
====================================

// Module: stage1_issue_ctrl
// PURPOSE
//  Stage-1 issue controller: buffers fetched instructions, sequences them one at a time
//  through the combinational ImmGen, and registers inst/pc/imm into the stage-1/2 boundary.
//  Sits between IMEM/icache response and stage 2; absorbs fetch/stall skew, handles redirect flush.
// PARAMETERS
//  DEPTH     2             instruction FIFO entries; power of 2, >=2
//  NOP_INST  32'h0000_0013 value driven on out_inst/dec_inst when not valid (addi x0,x0,0)
// PORTS
//  clk        in   1   clock, all state on posedge
//  reset      in   1   synchronous, active-high
//  in_valid   in   1   fetch has instruction
//  in_ready   out  1   FIFO can accept
//  in_inst    in   32  fetched instruction
//  in_pc      in   32  PC of in_inst
//  flush      in   1   redirect (branch/jump taken); discard everything buffered
//  dec_inst   out  32  FIFO head to ImmGen.inst (NOP_INST when FIFO empty)
//  dec_imm    in   32  ImmGen.imm for dec_inst (combinational, same cycle)
//  out_valid  out  1   stage-2 register holds a live instruction
//  out_ready  in   1   stage 2 accepts this cycle
//  out_inst   out  32  registered instruction
//  out_pc     out  32  registered PC
//  out_imm    out  32  registered immediate
//  stall_cnt  out  32  only with ISSUE_STALL_CNT_EN
// BEHAVIOUR
//  - Reset (sync, high): FIFO count=0, rd/wr ptr=0, out_valid=0, out_inst=NOP_INST,
//    out_pc=0, out_imm=0, stall_cnt=0. in_ready=0 while reset is high.
//  - in_ready = ~reset & ~flush & (count != DEPTH). No push-when-full even if popping same cycle.
//  - push = in_valid & in_ready: write {in_inst,in_pc} at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//  - load = (count != 0) & (~out_valid | out_ready) & ~flush: capture head inst, head pc and
//    dec_imm into out regs, out_valid<=1, rd_ptr++ (wraps). Else if out_ready, out_valid<=0
//    and out_inst<=NOP_INST (out_pc/out_imm hold).
//  - out regs hold value while out_valid & ~out_ready (stall); dec_inst stays on same head.
//  - count' = count + push - load; push and load same cycle legal at any count < DEPTH.
//  - Latency: instruction pushed at edge N is at head cycle N+1, out_valid cycle N+2 earliest
//    (out reg empty or out_ready). Throughput 1/cycle in steady state.
//  - flush (priority over push, load, stall): next edge count=0, ptrs=0, out_valid=0,
//    out_inst=NOP_INST; in_valid ignored that cycle. Flush with FIFO empty is harmless.
//  - Reset mid-stream equivalent to flush plus out_pc/out_imm/stall_cnt cleared.
//  - dec_imm sampled only on load edge; its value at other times is don't-care.
//  - Ordering: strict FIFO; no instruction dropped or duplicated absent flush/reset.
// CONFIGURATION
//  ISSUE_STALL_CNT_EN defined: stall_cnt counts cycles with out_valid & ~out_ready,
//    saturates at 32'hFFFF_FFFF, cleared only by reset (not flush).
//  Undefined: stall_cnt port absent; no counter logic; other behaviour identical.
// TESTING
//  1. Reset, push 0x00500093@pc 0x2000 -> out_valid cycle N+2, out_imm=5, out_pc=0x2000.
//  2. Back-to-back 4 pushes, out_ready=1 -> 4 outputs consecutive cycles, order preserved.
//  3. out_ready=0, push DEPTH+1 -> in_ready=0 after count=DEPTH; out regs hold; release
//     out_ready -> all drained in order, in_ready re-asserts next cycle.
//  4. flush with count=2, out_valid=1, in_valid=1 -> next cycle out_valid=0, out_inst=0x13,
//     in_ready=1, flushed-cycle in_inst never appears at output.
//  5. Pointer wrap: 3*DEPTH pushes interleaved with loads -> no loss, correct order.
//  6. ISSUE_STALL_CNT_EN: hold out_ready=0 7 cycles with out_valid=1 -> stall_cnt=7; flush
//     leaves stall_cnt=7; reset -> 0.

Source files
------------

// File: rtl/stage1_issue_ctrl.sv
// Stage-1 issue controller: instruction FIFO feeding ImmGen and the stage-1/2 boundary register.
// Optional stall-cycle counter enabled by defining ISSUE_STALL_CNT_EN.
module stage1_issue_ctrl #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_pc,
   input  logic        flush,
   output logic [31:0] dec_inst,
   input  logic [31:0] dec_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic [31:0] out_imm
`ifdef ISSUE_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [31:0]   inst_mem_q [DEPTH];
   logic [31:0]   inst_mem_d [DEPTH];
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   pc_mem_d   [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          out_valid_q, out_valid_d;
   logic [31:0]   out_inst_q, out_inst_d;
   logic [31:0]   out_pc_q, out_pc_d;
   logic [31:0]   out_imm_q, out_imm_d;
   logic          push, load, not_empty;

   always_comb begin
      not_empty   = (count_q != '0);
      in_ready    = ~reset & ~flush & (count_q != FULL);
      push        = in_valid & in_ready;
      load        = not_empty & (~out_valid_q | out_ready) & ~flush;
      dec_inst    = not_empty ? inst_mem_q[rd_ptr_q] : NOP_INST;

      inst_mem_d  = inst_mem_q;
      pc_mem_d    = pc_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      out_inst_d  = out_inst_q;
      out_pc_d    = out_pc_q;
      out_imm_d   = out_imm_q;

      if (push) begin
         inst_mem_d[wr_ptr_q] = in_inst;
         pc_mem_d[wr_ptr_q]   = in_pc;
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end

      if (load) begin
         out_valid_d = 1'b1;
         out_inst_d  = inst_mem_q[rd_ptr_q];
         out_pc_d    = pc_mem_q[rd_ptr_q];
         out_imm_d   = dec_imm;
         rd_ptr_d    = rd_ptr_q + PW'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_inst_d  = NOP_INST;
      end

      case ({push, load})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // push/load are already gated off by flush; only the clears remain
      if (flush) begin
         count_d     = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         out_valid_d = 1'b0;
         out_inst_d  = NOP_INST;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            inst_mem_q[i] <= '0;
            pc_mem_q[i]   <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_inst_q  <= NOP_INST;
         out_pc_q    <= '0;
         out_imm_q   <= '0;
      end else begin
         inst_mem_q  <= inst_mem_d;
         pc_mem_q    <= pc_mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_inst_q  <= out_inst_d;
         out_pc_q    <= out_pc_d;
         out_imm_q   <= out_imm_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_inst  = out_inst_q;
   assign out_pc    = out_pc_q;
   assign out_imm   = out_imm_q;

`ifdef ISSUE_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // A flush cycle is not a stall; the counter survives flush and saturates
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid_q & ~out_ready & ~flush & (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stage1_issue_ctrl.sv
// Self-checking bench for stage1_issue_ctrl against a queue-based reference model.
// Stall-counter scenario is built only when ISSUE_STALL_CNT_EN is defined.
module tb_stage1_issue_ctrl;

   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_inst, in_pc, dec_inst, dec_imm, out_inst, out_pc, out_imm;
`ifdef ISSUE_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   // reference model: buffered {inst,pc} entries plus the boundary register
   logic [63:0] m_q[$];
   logic        m_ov;
   logic [31:0] m_oinst, m_opc, m_oimm, m_stall;
   logic        exp_rdy;
   logic [31:0] exp_dec;

   always #5 clk = ~clk;

   function automatic logic [31:0] imm_of(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[31:20]};
   endfunction

   assign dec_imm = imm_of(dec_inst);

   stage1_issue_ctrl #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .dec_inst(dec_inst),
      .dec_imm(dec_imm), .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_pc(out_pc), .out_imm(out_imm)
`ifdef ISSUE_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   // Advance one clock and apply the behavioural rules to the model.
   task automatic tick();
      logic        rdy, ld, ps;
      logic [63:0] h;
      rdy = !reset && !flush && (m_q.size() != DEPTH);
      @(posedge clk);
      if (reset) begin
         m_q.delete(); m_ov = 0; m_oinst = NOP; m_opc = 0; m_oimm = 0; m_stall = 0;
      end else if (flush) begin
         m_q.delete(); m_ov = 0; m_oinst = NOP;
      end else begin
         if (m_ov && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         ld = (m_q.size() != 0) && (!m_ov || out_ready);
         ps = in_valid && rdy;
         if (ld) begin
            h = m_q.pop_front();
            m_ov = 1; m_oinst = h[63:32]; m_opc = h[31:0]; m_oimm = imm_of(h[63:32]);
         end else if (out_ready) begin
            m_ov = 0; m_oinst = NOP;
         end
         if (ps) m_q.push_back({in_inst, in_pc});
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1; flush = 0; in_valid = 1; in_inst = $urandom; in_pc = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < 2; i++) begin
         #1; checks++;
         if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
         tick();
      end
      reset = 0; in_valid = 0; #1;
      checks += 6;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      if (out_inst !== NOP)   begin failures++; $display("FAIL reset_out_inst got=%h exp=%h", out_inst, NOP); end
      if (out_pc !== 32'd0)   begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
      if (out_imm !== 32'd0)  begin failures++; $display("FAIL reset_out_imm got=%h exp=0", out_imm); end
      if (dec_inst !== NOP)   begin failures++; $display("FAIL reset_dec_inst got=%h exp=%h", dec_inst, NOP); end
      if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); end
   endtask

   task automatic test_single();
      out_ready = 1; in_valid = 1; in_inst = 32'h0050_0093; in_pc = 32'h2000;
      tick();
      in_valid = 0; #1;
      checks += 2;
      if (out_valid !== 1'b0)        begin failures++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
      if (dec_inst !== 32'h0050_0093) begin failures++; $display("FAIL single_dec_inst got=%h exp=00500093", dec_inst); end
      tick(); #1;
      checks += 4;
      if (out_valid !== 1'b1)         begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      if (out_imm !== 32'd5)          begin failures++; $display("FAIL single_imm got=%h exp=5", out_imm); end
      if (out_pc !== 32'h2000)        begin failures++; $display("FAIL single_pc got=%h exp=2000", out_pc); end
      if (out_inst !== 32'h0050_0093) begin failures++; $display("FAIL single_inst got=%h exp=00500093", out_inst); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] sent[$], got[$];
      out_ready = 1;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i < 4); in_inst = $urandom; in_pc = 32'h100 + 32'(4 * i);
         #1;
         exp_rdy = !reset && !flush && (m_q.size() != DEPTH);
         exp_dec = (m_q.size() != 0) ? m_q[0][63:32] : NOP;
         checks += 6;
         if (in_ready !== exp_rdy)  begin failures++; $display("FAIL b2b_in_ready got=%b exp=%b", in_ready, exp_rdy); end
         if (dec_inst !== exp_dec)  begin failures++; $display("FAIL b2b_dec_inst got=%h exp=%h", dec_inst, exp_dec); end
         if (out_valid !== m_ov)    begin failures++; $display("FAIL b2b_out_valid got=%b exp=%b", out_valid, m_ov); end
         if (out_inst !== m_oinst)  begin failures++; $display("FAIL b2b_out_inst got=%h exp=%h", out_inst, m_oinst); end
         if (out_pc !== m_opc)      begin failures++; $display("FAIL b2b_out_pc got=%h exp=%h", out_pc, m_opc); end
         if (out_imm !== m_oimm)    begin failures++; $display("FAIL b2b_out_imm got=%h exp=%h", out_imm, m_oimm); end
         if (in_valid) sent.push_back(in_inst);
         if (out_valid === 1'b1) got.push_back(out_inst);
         tick();
      end
      checks++;
      if (got.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== sent[i]) begin failures++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, got[i], sent[i]); end
      end
   endtask

   task automatic test_full_stall();
      logic [31:0] sent[$], got[$];
      int k = 0;
      out_ready = 0;
      for (int i = 0; i < 14; i++) begin
         if (i == 8) out_ready = 1;
         in_valid = (i < 8); in_inst = 32'hA000_0000 + 32'(k); in_pc = 32'h3000 + 32'(4 * k);
         #1;
         exp_rdy = !reset && !flush && (m_q.size() != DEPTH);
         exp_dec = (m_q.size() != 0) ? m_q[0][63:32] : NOP;
         checks += 6;
         if (in_ready !== exp_rdy)  begin failures++; $display("FAIL full_in_ready got=%b exp=%b", in_ready, exp_rdy); end
         if (dec_inst !== exp_dec)  begin failures++; $display("FAIL full_dec_inst got=%h exp=%h", dec_inst, exp_dec); end
         if (out_valid !== m_ov)    begin failures++; $display("FAIL full_out_valid got=%b exp=%b", out_valid, m_ov); end
         if (out_inst !== m_oinst)  begin failures++; $display("FAIL full_out_inst got=%h exp=%h", out_inst, m_oinst); end
         if (out_pc !== m_opc)      begin failures++; $display("FAIL full_out_pc got=%h exp=%h", out_pc, m_opc); end
         if (out_imm !== m_oimm)    begin failures++; $display("FAIL full_out_imm got=%h exp=%h", out_imm, m_oimm); end
         if (in_valid && exp_rdy) begin sent.push_back(in_inst); k++; end
         if (out_valid === 1'b1 && out_ready) got.push_back(out_inst);
         tick();
      end
      checks++;
      if (got.size() != DEPTH + 1) begin failures++; $display("FAIL full_drained got=%0d exp=%0d", got.size(), DEPTH + 1); end
      for (int i = 0; i < got.size() && i < sent.size(); i++) begin
         checks++;
         if (got[i] !== sent[i]) begin failures++; $display("FAIL full_order[%0d] got=%h exp=%h", i, got[i], sent[i]); end
      end
   endtask

   task automatic test_flush();
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_inst = 32'hB000_0000 + 32'(i); in_pc = 32'h4000 + 32'(4 * i);
         tick();
      end
      #1; checks += 2;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid got=%b exp=1", out_valid); end
      if (in_ready !== 1'b0)  begin failures++; $display("FAIL flush_pre_full got=%b exp=0", in_ready); end
      flush = 1; in_valid = 1; in_inst = 32'hDEAD_BEEF; in_pc = 32'h5000;
      tick();
      flush = 0; in_valid = 0; out_ready = 1; #1;
      checks += 4;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
      if (out_inst !== NOP)   begin failures++; $display("FAIL flush_out_inst got=%h exp=%h", out_inst, NOP); end
      if (in_ready !== 1'b1)  begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
      if (dec_inst !== NOP)   begin failures++; $display("FAIL flush_dec_inst got=%h exp=%h", dec_inst, NOP); end
      for (int i = 0; i < 4; i++) begin
         tick(); #1; checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_leak got=%b inst=%h exp=0", out_valid, out_inst); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 99) == 0);
         flush     = ($urandom_range(0, 24) == 0);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 9) < 7);
         in_inst   = $urandom; in_pc = $urandom;
         #1;
         exp_rdy = !reset && !flush && (m_q.size() != DEPTH);
         exp_dec = (m_q.size() != 0) ? m_q[0][63:32] : NOP;
         checks += 6;
         if (in_ready !== exp_rdy)  begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", i, in_ready, exp_rdy); end
         if (dec_inst !== exp_dec)  begin failures++; $display("FAIL rnd_dec_inst cyc=%0d got=%h exp=%h", i, dec_inst, exp_dec); end
         if (out_valid !== m_ov)    begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", i, out_valid, m_ov); end
         if (out_inst !== m_oinst)  begin failures++; $display("FAIL rnd_out_inst cyc=%0d got=%h exp=%h", i, out_inst, m_oinst); end
         if (out_pc !== m_opc)      begin failures++; $display("FAIL rnd_out_pc cyc=%0d got=%h exp=%h", i, out_pc, m_opc); end
         if (out_imm !== m_oimm)    begin failures++; $display("FAIL rnd_out_imm cyc=%0d got=%h exp=%h", i, out_imm, m_oimm); end
         tick();
      end
      reset = 0; flush = 0; in_valid = 0;
   endtask

`ifdef ISSUE_STALL_CNT_EN
   task automatic test_stall_cnt();
      reset = 1; flush = 0; in_valid = 0; out_ready = 0;
      tick();
      reset = 0; in_valid = 1; in_inst = 32'h0010_0093; in_pc = 32'h6000;
      tick();
      in_valid = 0;
      tick();
      for (int i = 0; i < 7; i++) tick();
      #1; checks += 2;
      if (out_valid !== 1'b1)  begin failures++; $display("FAIL stall_valid got=%b exp=1", out_valid); end
      if (stall_cnt !== 32'd7) begin failures++; $display("FAIL stall_cnt got=%0d exp=7", stall_cnt); end
      flush = 1; tick(); flush = 0; #1;
      checks++;
      if (stall_cnt !== 32'd7) begin failures++; $display("FAIL stall_after_flush got=%0d exp=7", stall_cnt); end
      reset = 1; tick(); reset = 0; #1;
      checks++;
      if (stall_cnt !== 32'd0) begin failures++; $display("FAIL stall_after_reset got=%0d exp=0", stall_cnt); end
   endtask
`endif

   initial begin
      reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_inst = '0; in_pc = '0;
      m_ov = 0; m_oinst = NOP; m_opc = 0; m_oimm = 0; m_stall = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_full_stall();
      test_flush();
      test_random();
`ifdef ISSUE_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
